uart_tx_fifo: RTL and testbench

Next-generation UART transmitter: parametrised data width and parity/stop format, plus a buffered write interface.
- Tx_DATA words are queued in an internal FIFO and serialised back-to-back onto Tx_D, LSB first.
- Uses the same baud_select encoding as the existing receiver, so the two link directly in loopback benches.
- Replaces the unbuffered transmitter in the UART system; software may burst-write up to FIFO_DEPTH words.

---
 rtl/uart_tx_fifo.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter. Words written on Tx_WR are queued
// in a small FIFO and serialised LSB first onto Tx_D with a configurable
// parity and stop format. The bit period, parity mode and stop count are
// latched per frame, so the configuration can change safely between frames.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_HZ     = 100000000,
  parameter int SIM_DIV    = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       baud_select,
  input  logic [1:0]                       parity_mode,
  input  logic                             stop2,
  input  logic                             Tx_EN,
  input  logic                             Tx_WR,
  input  logic [DATA_BITS-1:0]             Tx_DATA,
  output logic                             Tx_D,
  output logic                             Tx_BUSY,
  output logic                             Tx_FULL,
  output logic                             Tx_EMPTY,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  Tx_COUNT,
  output logic                             Tx_OVERFLOW
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Rounded clocks-per-bit for each baud_select code, shared with the receiver.
  function automatic logic [31:0] baud_div(input logic [2:0] sel);
    int baud;
    case (sel)
      3'd0:    baud = 300;
      3'd1:    baud = 1200;
      3'd2:    baud = 4800;
      3'd3:    baud = 9600;
      3'd4:    baud = 19200;
      3'd5:    baud = 38400;
      3'd6:    baud = 57600;
      default: baud = 115200;
    endcase
    return 32'((CLK_HZ + baud / 2) / baud);
  endfunction

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count_next;
  logic [DATA_BITS-1:0] head;
  logic                 push;
  logic                 pop;

  state_t               state;
  logic [31:0]          baud_cnt;
  logic [31:0]          div_lat;
  logic [31:0]          div_sel;
  logic [DATA_BITS-1:0] shift;
  logic [BW-1:0]        bit_idx;
  logic                 par_en;
  logic                 par_bit;
  logic                 stop2_lat;
  logic                 stop_second;
  logic                 bit_end;
  logic                 last_stop;

  assign head      = mem[rd_ptr];
  assign div_sel   = (SIM_DIV != 0) ? 32'(SIM_DIV) : baud_div(baud_select);
  assign bit_end   = (baud_cnt == div_lat - 32'd1);
  assign last_stop = (state == STOP) && bit_end && (stop_second || !stop2_lat);

  // A new frame starts from IDLE or seamlessly from the last stop cycle.
  assign pop  = Tx_EN && !Tx_EMPTY && ((state == IDLE) || last_stop);
  // A full FIFO still accepts a write when the same cycle frees a slot.
  assign push = Tx_WR && (!Tx_FULL || pop);

  // Next occupancy from this cycle's push/pop pair.
  always_comb begin
    count_next = Tx_COUNT;
    if (push && !pop) begin
      count_next = Tx_COUNT + CW'(1);
    end else if (pop && !push) begin
      count_next = Tx_COUNT - CW'(1);
    end
  end

  // FIFO storage; left unreset because the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= Tx_DATA;
    end
  end

  // FIFO pointers and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      Tx_COUNT    <= '0;
      Tx_FULL     <= 1'b0;
      Tx_EMPTY    <= 1'b1;
      Tx_OVERFLOW <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      Tx_COUNT    <= count_next;
      Tx_FULL     <= (count_next == CW'(FIFO_DEPTH));
      Tx_EMPTY    <= (count_next == '0);
      Tx_OVERFLOW <= Tx_WR && Tx_FULL && !pop;
    end
  end

  // Frame sequencer: latches word and format on pop, then walks the bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      Tx_D        <= 1'b1;
      Tx_BUSY     <= 1'b0;
      baud_cnt    <= '0;
      div_lat     <= 32'd1;
      shift       <= '0;
      bit_idx     <= '0;
      par_en      <= 1'b0;
      par_bit     <= 1'b0;
      stop2_lat   <= 1'b0;
      stop_second <= 1'b0;
    end else if (pop) begin
      state       <= START;
      Tx_D        <= 1'b0;
      Tx_BUSY     <= 1'b1;
      baud_cnt    <= '0;
      div_lat     <= div_sel;
      shift       <= head;
      bit_idx     <= '0;
      par_en      <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_bit     <= (^head) ^ (parity_mode == 2'b10);
      stop2_lat   <= stop2;
      stop_second <= 1'b0;
    end else if (state != IDLE) begin
      if (!bit_end) begin
        baud_cnt <= baud_cnt + 32'd1;
      end else begin
        baud_cnt <= '0;
        case (state)
          START: begin
            state <= DATA;
            Tx_D  <= shift[0];
          end
          DATA: begin
            if (bit_idx == BW'(DATA_BITS - 1)) begin
              if (par_en) begin
                state <= PARITY;
                Tx_D  <= par_bit;
              end else begin
                state <= STOP;
                Tx_D  <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              Tx_D    <= shift[1];
            end
          end
          PARITY: begin
            state <= STOP;
            Tx_D  <= 1'b1;
          end
          STOP: begin
            if (stop2_lat && !stop_second) begin
              stop_second <= 1'b1;
            end else begin
              state   <= IDLE;
              Tx_D    <= 1'b1;
              Tx_BUSY <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            Tx_D    <= 1'b1;
            Tx_BUSY <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scenario-driven bench for uart_tx_fifo. Expected line
// waveforms come from a frame model built from the UART framing rules.
module tb_uart_tx_fifo;

  localparam int DB   = 8;
  localparam int DIV  = 4;
  localparam int DIV7 = 868;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    baud_select;
  logic [1:0]    parity_mode;
  logic          stop2, Tx_EN, Tx_WR;
  logic [DB-1:0] Tx_DATA;
  logic          Tx_D, Tx_BUSY, Tx_FULL, Tx_EMPTY, Tx_OVERFLOW;
  logic [2:0]    Tx_COUNT;

  logic [2:0]    baud7;
  logic [1:0]    pm7;
  logic          s27, en7, wr7;
  logic [6:0]    data7;
  logic          Tx_D7, busy7, full7, empty7, ovf7;
  logic [2:0]    count7;

  int n_cmp = 0;
  int n_bad = 0;

  logic cap_d    [0:1023];
  logic cap_busy [0:1023];
  logic cap_ovf  [0:1023];

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(4), .CLK_HZ(100000000), .SIM_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .baud_select(baud_select), .parity_mode(parity_mode),
    .stop2(stop2), .Tx_EN(Tx_EN), .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA), .Tx_D(Tx_D),
    .Tx_BUSY(Tx_BUSY), .Tx_FULL(Tx_FULL), .Tx_EMPTY(Tx_EMPTY), .Tx_COUNT(Tx_COUNT),
    .Tx_OVERFLOW(Tx_OVERFLOW)
  );

  uart_tx_fifo #(.DATA_BITS(7), .FIFO_DEPTH(4), .CLK_HZ(100000000), .SIM_DIV(0)) dut7 (
    .clk(clk), .reset(reset), .baud_select(baud7), .parity_mode(pm7),
    .stop2(s27), .Tx_EN(en7), .Tx_WR(wr7), .Tx_DATA(data7), .Tx_D(Tx_D7),
    .Tx_BUSY(busy7), .Tx_FULL(full7), .Tx_EMPTY(empty7), .Tx_COUNT(count7),
    .Tx_OVERFLOW(ovf7)
  );

  // Number of bit periods in one frame.
  function automatic int frame_len(input logic [1:0] pm, input logic s2);
    return 1 + DB + (((pm == 2'b01) || (pm == 2'b10)) ? 1 : 0) + (s2 ? 2 : 1);
  endfunction

  // Line level during bit period k of a frame carrying d.
  function automatic logic frame_bit(input logic [DB-1:0] d, input logic [1:0] pm, input int k);
    int ones;
    ones = $countones(d);
    if (k == 0) return 1'b0;
    if (k <= DB) return d[k-1];
    if (k == DB + 1 && pm == 2'b01) return (ones % 2) == 1;
    if (k == DB + 1 && pm == 2'b10) return (ones % 2) == 0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DB-1:0] d);
    Tx_WR   = 1'b1;
    Tx_DATA = d;
    tick();
    Tx_WR   = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      cap_d[i]    = Tx_D;
      cap_busy[i] = Tx_BUSY;
      cap_ovf[i]  = Tx_OVERFLOW;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Tx_EN = 1'b1;
    tick();
    n_cmp++; if (Tx_D !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_Tx_D got %b want 1", Tx_D); end
    n_cmp++; if (Tx_BUSY !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_Tx_BUSY got %b want 0", Tx_BUSY); end
    n_cmp++; if (Tx_FULL !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_Tx_FULL got %b want 0", Tx_FULL); end
    n_cmp++; if (Tx_EMPTY !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_Tx_EMPTY got %b want 1", Tx_EMPTY); end
    n_cmp++; if (Tx_COUNT !== 3'd0) begin n_bad++; $display("[TB] FAIL reset_Tx_COUNT got %0d want 0", Tx_COUNT); end
    n_cmp++; if (Tx_OVERFLOW !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_Tx_OVERFLOW got %b want 0", Tx_OVERFLOW); end
    n_cmp++; if (Tx_D7 !== 1'b1 || busy7 !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_dut7 got d=%b busy=%b want 1/0", Tx_D7, busy7); end
    tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (Tx_BUSY !== 1'b0 || Tx_D !== 1'b1) begin n_bad++; $display("[TB] FAIL idle_after_reset got busy=%b d=%b want 0/1", Tx_BUSY, Tx_D); end
  endtask

  task automatic test_even_parity();
    logic [DB-1:0] d;
    int L, busy_cycles;
    d = 8'hBA;
    parity_mode = 2'b01; stop2 = 1'b0; Tx_EN = 1'b1;
    L = frame_len(2'b01, 1'b0);
    write_word(d);
    n_cmp++; if (Tx_COUNT !== 3'd1 || Tx_BUSY !== 1'b0 || Tx_D !== 1'b1) begin n_bad++; $display("[TB] FAIL even_cycle1 got count=%0d busy=%b d=%b want 1/0/1", Tx_COUNT, Tx_BUSY, Tx_D); end
    tick();
    n_cmp++; if (Tx_EMPTY !== 1'b1) begin n_bad++; $display("[TB] FAIL even_empty_cycle2 got %b want 1", Tx_EMPTY); end
    capture(L * DIV + 1);
    busy_cycles = 0;
    for (int i = 0; i < L * DIV; i++) begin
      if (cap_busy[i] === 1'b1) busy_cycles++;
      n_cmp++;
      if (cap_d[i] !== frame_bit(d, 2'b01, i / DIV)) begin
        n_bad++; $display("[TB] FAIL even_line cycle %0d got %b want %b", i, cap_d[i], frame_bit(d, 2'b01, i / DIV));
      end
    end
    n_cmp++; if (busy_cycles != L * DIV || cap_busy[L*DIV] !== 1'b0) begin n_bad++; $display("[TB] FAIL even_busy_len got %0d (end %b) want %0d (end 0)", busy_cycles, cap_busy[L*DIV], L * DIV); end
    n_cmp++; if (cap_d[L*DIV] !== 1'b1) begin n_bad++; $display("[TB] FAIL even_idle_line got %b want 1", cap_d[L*DIV]); end
  endtask

  task automatic test_odd_stop2();
    logic [DB-1:0] d;
    int L;
    d = 8'hEA;
    parity_mode = 2'b10; stop2 = 1'b1; Tx_EN = 1'b1;
    L = frame_len(2'b10, 1'b1);
    write_word(d);
    tick();
    capture(L * DIV + 1);
    for (int i = 0; i < L * DIV; i++) begin
      n_cmp++;
      if (cap_d[i] !== frame_bit(d, 2'b10, i / DIV) || cap_busy[i] !== 1'b1) begin
        n_bad++; $display("[TB] FAIL odd_line cycle %0d got d=%b busy=%b want d=%b busy=1", i, cap_d[i], cap_busy[i], frame_bit(d, 2'b10, i / DIV));
      end
    end
    n_cmp++; if (cap_d[9*DIV + DIV/2] !== 1'b0) begin n_bad++; $display("[TB] FAIL odd_parity_bit got %b want 0", cap_d[9*DIV + DIV/2]); end
    n_cmp++; if (cap_busy[L*DIV] !== 1'b0) begin n_bad++; $display("[TB] FAIL odd_busy_end got %b want 0", cap_busy[L*DIV]); end
  endtask

  task automatic test_overflow_burst();
    int L, fl, pulses;
    logic [DB-1:0] w;
    parity_mode = 2'b00; stop2 = 1'b0; Tx_EN = 1'b0;
    L = frame_len(2'b00, 1'b0);
    fl = L * DIV;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      write_word(DB'(i + 1));
      if (Tx_OVERFLOW === 1'b1) pulses++;
      n_cmp++;
      if (Tx_COUNT !== 3'((i < 4) ? i + 1 : 4) || Tx_OVERFLOW !== (i == 4)) begin
        n_bad++; $display("[TB] FAIL burst_write %0d got count=%0d ovf=%b want %0d/%b", i, Tx_COUNT, Tx_OVERFLOW, (i < 4) ? i + 1 : 4, i == 4);
      end
    end
    n_cmp++; if (Tx_FULL !== 1'b1 || Tx_BUSY !== 1'b0) begin n_bad++; $display("[TB] FAIL burst_full got full=%b busy=%b want 1/0", Tx_FULL, Tx_BUSY); end
    tick();
    if (Tx_OVERFLOW === 1'b1) pulses++;
    n_cmp++; if (pulses != 1) begin n_bad++; $display("[TB] FAIL burst_ovf_pulses got %0d want 1", pulses); end
    Tx_EN = 1'b1;
    tick();
    capture(4 * fl + 1);
    for (int i = 0; i < 4 * fl; i++) begin
      w = DB'(i / fl + 1);
      n_cmp++;
      if (cap_d[i] !== frame_bit(w, 2'b00, (i % fl) / DIV) || cap_busy[i] !== 1'b1) begin
        n_bad++; $display("[TB] FAIL burst_line cycle %0d got d=%b busy=%b want d=%b busy=1", i, cap_d[i], cap_busy[i], frame_bit(w, 2'b00, (i % fl) / DIV));
      end
    end
    n_cmp++; if (cap_busy[4*fl] !== 1'b0 || Tx_EMPTY !== 1'b1) begin n_bad++; $display("[TB] FAIL burst_drain got busy=%b empty=%b want 0/1", cap_busy[4*fl], Tx_EMPTY); end
  endtask

  task automatic test_full_pop_write();
    logic [DB-1:0] w [6];
    int L, fl, ovf_seen;
    parity_mode = 2'b00; stop2 = 1'b0; Tx_EN = 1'b1;
    L = frame_len(2'b00, 1'b0);
    fl = L * DIV;
    for (int i = 0; i < 6; i++) w[i] = DB'($urandom);
    for (int i = 0; i < 5; i++) write_word(w[i]);
    n_cmp++; if (Tx_COUNT !== 3'd4 || Tx_FULL !== 1'b1) begin n_bad++; $display("[TB] FAIL fpw_fill got count=%0d full=%b want 4/1", Tx_COUNT, Tx_FULL); end
    for (int i = 5; i < 1 + fl; i++) tick();
    n_cmp++; if (Tx_D !== 1'b1 || Tx_BUSY !== 1'b1) begin n_bad++; $display("[TB] FAIL fpw_stop_cycle got d=%b busy=%b want 1/1", Tx_D, Tx_BUSY); end
    write_word(w[5]);
    n_cmp++; if (Tx_COUNT !== 3'd4 || Tx_OVERFLOW !== 1'b0 || Tx_D !== 1'b0) begin n_bad++; $display("[TB] FAIL fpw_accept got count=%0d ovf=%b d=%b want 4/0/0", Tx_COUNT, Tx_OVERFLOW, Tx_D); end
    capture(5 * fl + 1);
    ovf_seen = 0;
    for (int i = 0; i < 5 * fl; i++) begin
      if (cap_ovf[i] === 1'b1) ovf_seen++;
      n_cmp++;
      if (cap_d[i] !== frame_bit(w[i / fl + 1], 2'b00, (i % fl) / DIV)) begin
        n_bad++; $display("[TB] FAIL fpw_line cycle %0d got %b want %b", i, cap_d[i], frame_bit(w[i / fl + 1], 2'b00, (i % fl) / DIV));
      end
    end
    n_cmp++; if (ovf_seen != 0 || cap_busy[5*fl] !== 1'b0) begin n_bad++; $display("[TB] FAIL fpw_tail got ovf=%0d busy=%b want 0/0", ovf_seen, cap_busy[5*fl]); end
  endtask

  task automatic test_midframe_config();
    logic [DB-1:0] d;
    int L;
    d = DB'($urandom);
    parity_mode = 2'b01; stop2 = 1'b0; Tx_EN = 1'b1; baud_select = 3'b011;
    L = frame_len(2'b01, 1'b0);
    write_word(d);
    tick();
    for (int i = 0; i <= L * DIV; i++) begin
      if (i == 6) begin
        parity_mode = 2'b10; stop2 = 1'b1; baud_select = 3'($urandom);
      end
      n_cmp++;
      if (i < L * DIV && (Tx_D !== frame_bit(d, 2'b01, i / DIV) || Tx_BUSY !== 1'b1)) begin
        n_bad++; $display("[TB] FAIL midcfg_line cycle %0d got d=%b busy=%b want d=%b busy=1", i, Tx_D, Tx_BUSY, frame_bit(d, 2'b01, i / DIV));
      end else if (i == L * DIV && (Tx_BUSY !== 1'b0 || Tx_D !== 1'b1)) begin
        n_bad++; $display("[TB] FAIL midcfg_end got busy=%b d=%b want 0/1", Tx_BUSY, Tx_D);
      end
      tick();
    end
    parity_mode = 2'b00; stop2 = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [DB-1:0] d;
    d = DB'($urandom);
    d[2] = 1'b0;
    parity_mode = 2'b00; stop2 = 1'b0; Tx_EN = 1'b1;
    write_word(d);
    write_word(DB'($urandom));
    write_word(DB'($urandom));
    for (int i = 3; i < 2 + 3 * DIV; i++) tick();
    n_cmp++; if (Tx_BUSY !== 1'b1 || Tx_D !== 1'b0 || Tx_COUNT !== 3'd2) begin n_bad++; $display("[TB] FAIL rstmid_pre got busy=%b d=%b count=%0d want 1/0/2", Tx_BUSY, Tx_D, Tx_COUNT); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (Tx_D !== 1'b1 || Tx_BUSY !== 1'b0 || Tx_COUNT !== 3'd0 || Tx_EMPTY !== 1'b1) begin
      n_bad++; $display("[TB] FAIL rstmid_post got d=%b busy=%b count=%0d empty=%b want 1/0/0/1", Tx_D, Tx_BUSY, Tx_COUNT, Tx_EMPTY);
    end
    for (int i = 0; i < 3 * DIV; i++) begin
      tick();
      n_cmp++;
      if (Tx_D !== 1'b1 || Tx_BUSY !== 1'b0) begin
        n_bad++; $display("[TB] FAIL rstmid_quiet cycle %0d got d=%b busy=%b want 1/0", i, Tx_D, Tx_BUSY);
      end
    end
  endtask

  task automatic test_random_bursts();
    logic [DB-1:0] q [$];
    logic [1:0] pm;
    logic s2;
    int n, L, fl, gap;
    for (int it = 0; it < 6; it++) begin
      q.delete();
      pm = 2'($urandom_range(0, 3));
      s2 = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 4);
      gap = $urandom_range(0, 3);
      parity_mode = pm; stop2 = s2; Tx_EN = 1'b0;
      for (int g = 0; g < gap; g++) tick();
      for (int k = 0; k < n; k++) begin
        q.push_back(DB'($urandom));
        write_word(q[k]);
      end
      n_cmp++; if (Tx_COUNT !== 3'(n) || Tx_BUSY !== 1'b0) begin n_bad++; $display("[TB] FAIL rnd_queued it %0d got count=%0d busy=%b want %0d/0", it, Tx_COUNT, Tx_BUSY, n); end
      L = frame_len(pm, s2);
      fl = L * DIV;
      Tx_EN = 1'b1;
      tick();
      capture(n * fl + 1);
      for (int i = 0; i < n * fl; i++) begin
        n_cmp++;
        if (cap_d[i] !== frame_bit(q[i / fl], pm, (i % fl) / DIV) || cap_busy[i] !== 1'b1) begin
          n_bad++; $display("[TB] FAIL rnd_line it %0d cycle %0d got d=%b busy=%b want d=%b busy=1", it, i, cap_d[i], cap_busy[i], frame_bit(q[i / fl], pm, (i % fl) / DIV));
        end
      end
      n_cmp++; if (cap_busy[n*fl] !== 1'b0 || cap_d[n*fl] !== 1'b1) begin n_bad++; $display("[TB] FAIL rnd_end it %0d got busy=%b d=%b want 0/1", it, cap_busy[n*fl], cap_d[n*fl]); end
    end
  endtask

  // Behavioural receiver for the 7-bit link: mid-bit sampling, no parity.
  task automatic rx7(output logic [6:0] data, output logic ferr, output logic ok, output int rise_at);
    ok = 1'b0; ferr = 1'b0; data = '0; rise_at = -1;
    for (int t = 0; t < 20000 && Tx_D7 !== 1'b0; t++) tick();
    if (Tx_D7 !== 1'b0) return;
    for (int c = 0; c <= 8 * DIV7 + DIV7 / 2; c++) begin
      if (rise_at < 0 && Tx_D7 === 1'b1) rise_at = c;
      if (c % DIV7 == DIV7 / 2) begin
        if (c / DIV7 == 0 && Tx_D7 !== 1'b0) ferr = 1'b1;
        else if (c / DIV7 >= 1 && c / DIV7 <= 7) data[c / DIV7 - 1] = Tx_D7;
        else if (c / DIV7 == 8 && Tx_D7 !== 1'b1) ferr = 1'b1;
      end
      tick();
    end
    ok = 1'b1;
  endtask

  task automatic test_loopback();
    logic [6:0] words [2];
    logic [6:0] got;
    logic ferr, ok;
    int rise, lo;
    words[0] = 7'h55;
    words[1] = 7'h2A;
    baud7 = 3'b111; pm7 = 2'b00; s27 = 1'b0; en7 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wr7 = 1'b1; data7 = words[k];
      tick();
    end
    wr7 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rx7(got, ferr, ok, rise);
      lo = 0;
      while (lo < 7 && !words[k][lo]) lo++;
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("[TB] FAIL loop_valid frame %0d got no frame want frame", k); end
      n_cmp++; if (got !== words[k]) begin n_bad++; $display("[TB] FAIL loop_data frame %0d got %h want %h", k, got, words[k]); end
      n_cmp++; if (ferr !== 1'b0) begin n_bad++; $display("[TB] FAIL loop_ferror frame %0d got %b want 0", k, ferr); end
      n_cmp++; if (rise != DIV7 * (lo + 1)) begin n_bad++; $display("[TB] FAIL loop_period frame %0d got first rise %0d want %0d", k, rise, DIV7 * (lo + 1)); end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; baud_select = 3'b000; parity_mode = 2'b00; stop2 = 1'b0;
    Tx_EN = 1'b0; Tx_WR = 1'b0; Tx_DATA = '0;
    baud7 = 3'b111; pm7 = 2'b00; s27 = 1'b0; en7 = 1'b0; wr7 = 1'b0; data7 = '0;
    test_reset();
    test_even_parity();
    test_odd_stop2();
    test_overflow_burst();
    test_full_pop_write();
    test_midframe_config();
    test_reset_midframe();
    test_random_bursts();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
